// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-outstanding instruction fetch sequencer with redirect and drain
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_offset
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;

  logic signed [31:0] target_sum;
  logic [31:0]        target;

  // Wrapping 32-bit add; bit 0 cleared so targets are always halfword aligned.
  assign target_sum = $signed(redirect_base) + $signed(redirect_offset);
  assign target     = target_sum & ~32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drain_addr_q  <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP;
      instr_pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) pc_q <= target;
          state_q <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            pc_q <= target;
            if (imem_ready) begin
              state_q <= FETCH;
            end else begin
              drain_addr_q <= pc_q;
              state_q      <= DRAIN;
            end
          end else if (imem_ready) begin
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + PC_INC;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q          <= target;
            instr_valid_q <= 1'b0;
            state_q       <= FETCH;
          end else if (!stall) begin
            instr_valid_q <= 1'b0;
            state_q       <= FETCH;
          end
        end
        DRAIN: begin
          // The abandoned response is swallowed; the newest redirect target wins.
          if (redirect) pc_q <= target;
          if (imem_ready) state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule
